// File: rtl/acc_sequencer.sv
// Instruction sequencer for the 8-bit accumulator datapath: fetch/decode/issue of control strobes.
// Optional retired-instruction counter enabled by defining ACC_SEQ_INSTR_COUNT_EN.
`timescale 1ns/1ps

module acc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr_data,
  input  logic       instr_valid,
  output logic       instr_req,
  output logic       LoadAcc,
  output logic       DumpAcc,
  output logic       SelAcc0,
  output logic       SelAcc1,
  output logic [7:0] imm_out,
  output logic [3:0] reg_addr,
  output logic       reg_rd,
  output logic       reg_wr,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       halted,
  output logic [15:0] instr_count
);

  // state  | meaning
  // IDLE   | first cycle out of reset, no request yet
  // FETCH  | requesting the instruction byte
  // DECODE | IR valid; NOP/illegal/HALT retire here
  // IMM    | requesting the LDI immediate byte
  // EXEC   | issue strobes; LDI/MOV retire here
  // WB     | ALU result loaded into accumulator; ALU retires here
  // HALT   | parked until reset

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] ir;
  logic [7:0] imm;

  logic [3:0] opcode;
  logic       is_nop, is_ldi, is_mov_ar, is_mov_ra, is_alu, is_halt, is_illegal;

  assign opcode     = ir[7:4];
  assign is_nop     = (opcode == 4'h0);
  assign is_ldi     = (opcode == 4'h1);
  assign is_mov_ar  = (opcode == 4'h2);
  assign is_mov_ra  = (opcode == 4'h3);
  assign is_alu     = (opcode[3:2] == 2'b01);
  assign is_halt    = (opcode == 4'hF);
  assign is_illegal = opcode[3] && !is_halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= 8'h00;
      imm   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && instr_valid) ir  <= instr_data;
      if (state == S_IMM   && instr_valid) imm <= instr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    instr_req = 1'b0;
    LoadAcc   = 1'b0;
    DumpAcc   = 1'b0;
    SelAcc0   = 1'b0;
    SelAcc1   = 1'b0;
    imm_out   = 8'h00;
    reg_addr  = 4'h0;
    reg_rd    = 1'b0;
    reg_wr    = 1'b0;
    alu_op    = 2'b00;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        illegal = is_illegal;
        if (is_ldi)                      state_nxt = S_IMM;
        else if (is_mov_ar || is_mov_ra || is_alu) state_nxt = S_EXEC;
        else if (is_halt)                state_nxt = S_HALT;
        else                             state_nxt = S_FETCH;
      end
      S_IMM: begin
        instr_req = 1'b1;
        if (instr_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (is_ldi) begin
          LoadAcc = 1'b1;
          imm_out = imm;
        end else if (is_mov_ar) begin
          reg_addr = ir[3:0];
          reg_rd   = 1'b1;
          SelAcc0  = 1'b1;
          LoadAcc  = 1'b1;
        end else if (is_mov_ra) begin
          reg_addr = ir[3:0];
          DumpAcc  = 1'b1;
          reg_wr   = 1'b1;
        end else if (is_alu) begin
          reg_addr  = ir[3:0];
          reg_rd    = 1'b1;
          alu_op    = ir[5:4];
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        SelAcc1   = 1'b1;
        LoadAcc   = 1'b1;
        alu_op    = ir[5:4];
        state_nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef ACC_SEQ_INSTR_COUNT_EN
  logic        retire;
  logic [15:0] count_q;

  // EXEC only retires for LDI/MOV; ALU instructions retire one cycle later in WB
  assign retire = (state == S_DECODE && (is_nop || is_illegal || is_halt)) ||
                  (state == S_EXEC && !is_alu) ||
                  (state == S_WB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count_q <= 16'h0000;
    else if (retire) count_q <= count_q + 16'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: per-instruction cycle-pattern model plus directed spot checks.
// Count expectations follow ACC_SEQ_INSTR_COUNT_EN the same way the design build does.
`timescale 1ns/1ps

module tb_acc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  instr_data;
  logic        instr_valid;
  logic        instr_req, LoadAcc, DumpAcc, SelAcc0, SelAcc1;
  logic [7:0]  imm_out;
  logic [3:0]  reg_addr;
  logic        reg_rd, reg_wr;
  logic [1:0]  alu_op;
  logic        illegal, halted;
  logic [15:0] instr_count;

  acc_sequencer dut (
    .clk(clk), .reset(reset), .instr_data(instr_data), .instr_valid(instr_valid),
    .instr_req(instr_req), .LoadAcc(LoadAcc), .DumpAcc(DumpAcc), .SelAcc0(SelAcc0),
    .SelAcc1(SelAcc1), .imm_out(imm_out), .reg_addr(reg_addr), .reg_rd(reg_rd),
    .reg_wr(reg_wr), .alu_op(alu_op), .illegal(illegal), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [38:0] act;
  assign act = {instr_req, LoadAcc, DumpAcc, SelAcc0, SelAcc1, imm_out, reg_addr,
                reg_rd, reg_wr, alu_op, illegal, halted, instr_count};

  typedef struct {
    logic [38:0] v;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] cnt = 16'h0000;
  int          n_checks = 0;
  int          n_fail = 0;
  int          req_cyc = 0, load_cyc = 0, ill_cyc = 0, halt_cyc = 0;
  logic [7:0]  last_imm = 8'h00;
  logic [1:0]  last_rd_op = 2'b00;
  logic [3:0]  last_rd_addr = 4'h0;

  // Expected outputs for a cycle; the counter field carries the count before any retirement edge.
  function automatic logic [38:0] mk(logic req, logic ld, logic dp, logic s0, logic s1,
                                     logic [7:0] im, logic [3:0] a, logic rd, logic wr,
                                     logic [1:0] op, logic il, logic ht);
    return {req, ld, dp, s0, s1, im, a, rd, wr, op, il, ht, cnt};
  endfunction

  function automatic logic [38:0] idle_rec();
    return mk(0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 2'b00, 0, 0);
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h expected %h", e.tag, $time, act, e.v);
      end
    end
  end

  always @(negedge clk) begin
    if (instr_req) req_cyc++;
    if (LoadAcc)   load_cyc++;
    if (illegal)   ill_cyc++;
    if (halted)    halt_cyc++;
    if (LoadAcc && !SelAcc0 && !SelAcc1) last_imm = imm_out;
    if (reg_rd) begin
      last_rd_op   = alu_op;
      last_rd_addr = reg_addr;
    end
  end

  task automatic begin_cycle(logic [38:0] v, logic valid, logic [7:0] data, string tag);
    instr_valid = valid;
    instr_data  = data;
    exp_q.push_back('{v: v, tag: tag});
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(logic [38:0] v, logic valid, logic [7:0] data, string tag);
    begin_cycle(v, valid, data, tag);
    end_cycle();
  endtask

  // Reset asserted mid-cycle: outputs must drop at once, then one reset cycle and one IDLE cycle.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {25'b0, act}, 64'h0);
    cnt = 16'h0000;
    end_cycle();
    cyc(idle_rec(), 1'($urandom_range(0, 1)), 8'($urandom), "in_reset");
    reset = 1'b0;
    cyc(idle_rec(), 1'($urandom_range(0, 1)), 8'($urandom), "idle");
  endtask

  task automatic fin(logic [38:0] v, string tag, bit do_rst);
    begin_cycle(v, 1'($urandom_range(0, 1)), 8'($urandom), tag);
    if (do_rst) mid_reset();
    else begin
`ifdef ACC_SEQ_INSTR_COUNT_EN
      cnt = cnt + 16'd1;
`endif
      end_cycle();
    end
  endtask

  // One whole instruction from FETCH entry to retirement, built from the per-opcode cycle pattern.
  task automatic run_instr(logic [7:0] op, logic [7:0] immv, int w1, int w2, bit rst_last,
                           int halt_cycles);
    logic [3:0] opc;
    logic [3:0] ra;
    opc = op[7:4];
    ra  = op[3:0];
    for (int i = 0; i < w1; i++)
      cyc(mk(1, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 2'b00, 0, 0), 1'b0, 8'($urandom), "fetch_wait");
    cyc(mk(1, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 2'b00, 0, 0), 1'b1, op, "fetch");
    if (opc == 4'h0 || opc >= 4'h8) begin
      logic il;
      il = (opc >= 4'h8 && opc <= 4'hE);
      fin(mk(0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 2'b00, il, 0), "decode_retire",
          rst_last && opc != 4'hF);
      if (opc == 4'hF) begin
        for (int i = 0; i < halt_cycles - 1; i++)
          cyc(mk(0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 2'b00, 0, 1), 1'($urandom_range(0, 1)),
              8'($urandom), "halt");
        begin_cycle(mk(0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 2'b00, 0, 1), 1'b1, 8'($urandom),
                    "halt_last");
        mid_reset();
      end
    end else begin
      cyc(idle_rec(), 1'($urandom_range(0, 1)), 8'($urandom), "decode");
      if (opc == 4'h1) begin
        for (int i = 0; i < w2; i++)
          cyc(mk(1, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 2'b00, 0, 0), 1'b0, 8'($urandom), "imm_wait");
        cyc(mk(1, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 2'b00, 0, 0), 1'b1, immv, "imm");
        fin(mk(0, 1, 0, 0, 0, immv, 4'h0, 0, 0, 2'b00, 0, 0), "exec_ldi", rst_last);
      end else if (opc == 4'h2) begin
        fin(mk(0, 1, 0, 1, 0, 8'h00, ra, 1, 0, 2'b00, 0, 0), "exec_mov_ar", rst_last);
      end else if (opc == 4'h3) begin
        fin(mk(0, 0, 1, 0, 0, 8'h00, ra, 0, 1, 2'b00, 0, 0), "exec_mov_ra", rst_last);
      end else begin
        cyc(mk(0, 0, 0, 0, 0, 8'h00, ra, 1, 0, opc[1:0], 0, 0), 1'($urandom_range(0, 1)),
            8'($urandom), "exec_alu");
        fin(mk(0, 1, 0, 0, 1, 8'h00, 4'h0, 0, 0, opc[1:0], 0, 0), "wb_alu", rst_last);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, l0, i0, h0;
    int opc, w1, w2;
    logic [7:0] op;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(idle_rec(), 1'b1, 8'($urandom), "reset_state");
    reset = 1'b0;
    cyc(idle_rec(), 1'b1, 8'h00, "idle");

    // NOP with valid held high
    r0 = req_cyc;
    run_instr(8'h00, 8'h00, 0, 0, 0, 0);
    chk("nop_req_cycles", 64'(req_cyc - r0), 64'd1);
`ifdef ACC_SEQ_INSTR_COUNT_EN
    chk("nop_count", 64'(instr_count), 64'd1);
`else
    chk("nop_count", 64'(instr_count), 64'd0);
`endif

    // LDI 0xA5
    l0 = load_cyc;
    run_instr(8'h10, 8'hA5, 0, 0, 0, 0);
    chk("ldi_load_cycles", 64'(load_cyc - l0), 64'd1);
    chk("ldi_imm", 64'(last_imm), 64'hA5);

    // SUB A,R7
    l0 = load_cyc;
    run_instr(8'h57, 8'h00, 0, 0, 0, 0);
    chk("sub_alu_op", 64'(last_rd_op), 64'h1);
    chk("sub_reg_addr", 64'(last_rd_addr), 64'h7);
    chk("sub_load_cycles", 64'(load_cyc - l0), 64'd1);

    // MOV R3<-A with three wait states
    r0 = req_cyc;
    l0 = load_cyc;
    run_instr(8'h33, 8'h00, 3, 0, 0, 0);
    chk("mov_ra_req_cycles", 64'(req_cyc - r0), 64'd4);
    chk("mov_ra_no_load", 64'(load_cyc - l0), 64'd0);

    // illegal then HALT for 20 cycles, reset mid-HALT
    i0 = ill_cyc;
    run_instr(8'h9C, 8'h00, 0, 0, 0, 0);
    chk("illegal_pulse", 64'(ill_cyc - i0), 64'd1);
    r0 = req_cyc;
    h0 = halt_cyc;
    run_instr(8'hF0, 8'h00, 0, 0, 0, 20);
    chk("halt_req_cycles", 64'(req_cyc - r0), 64'd1);
    chk("halt_cycles", 64'(halt_cyc - h0), 64'd20);

    // reset while LDI is in EXEC: no LoadAcc may survive the reset
    l0 = load_cyc;
    run_instr(8'h1F, 8'h3C, 1, 2, 1, 0);
    chk("ldi_reset_load_cycles", 64'(load_cyc - l0), 64'd1);

    for (int n = 0; n < 300; n++) begin
      opc = $urandom_range(0, 15);
      if (opc == 15 && $urandom_range(0, 3) != 0) opc = 0;
      op = {4'(opc), 4'($urandom_range(0, 15))};
      w1 = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      w2 = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      run_instr(op, 8'($urandom), w1, w2, $urandom_range(0, 15) == 0, $urandom_range(1, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
